// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor (a - b), LSB first, start/done handshake

// Single-bit full-subtractor cell: one difference bit and one borrow per call.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// Bit-serial subtractor wrapping one full_subtractor cell.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits never wrap mid-operation.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  // Holds the WIDTH-1 difference bits produced so far; the last bit joins them on the final edge.
  logic [WIDTH-2:0]   res_sr;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt;

  logic               d_bit;
  logic               b_bit;
  logic [WIDTH-1:0]   res_next;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .diff (d_bit),
    .bout (b_bit)
  );

  // New difference bit enters at the MSB; after WIDTH edges the LSB-first bits line up.
  assign res_next = {d_bit, res_sr};

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end

        SHIFT: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= res_next[WIDTH-1:1];
          borrow_q <= b_bit;
          busy     <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            difference <= res_next;
            borrow_out <= b_bit;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH 8, 3, 4)

module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, bo3;
  logic [2:0] diff3;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .difference(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .difference(diff3), .borrow_out(bo3)
  );

  serial_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .difference(diff4), .borrow_out(bo4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_busy(input int sel);
    case (sel)
      0:       return busy8;
      1:       return busy3;
      default: return busy4;
    endcase
  endfunction

  function automatic logic rd_done(input int sel);
    case (sel)
      0:       return done8;
      1:       return done3;
      default: return done4;
    endcase
  endfunction

  function automatic logic [7:0] rd_diff(input int sel);
    case (sel)
      0:       return diff8;
      1:       return {5'd0, diff3};
      default: return {4'd0, diff4};
    endcase
  endfunction

  function automatic logic rd_bo(input int sel);
    case (sel)
      0:       return bo8;
      1:       return bo3;
      default: return bo4;
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [7:0] ai, input logic [7:0] bi);
    case (sel)
      0:       begin start8 = s; a8 = ai;      b8 = bi;      end
      1:       begin start3 = s; a3 = ai[2:0]; b3 = bi[2:0]; end
      default: begin start4 = s; a4 = ai[3:0]; b4 = bi[3:0]; end
    endcase
  endtask

  // Called #1 after the accepting edge; lat counts edges including the accepting one.
  task automatic wait_done(input int sel, output int lat, output int bcyc,
                           output logic [7:0] d, output logic bo, output bit hold_ok);
    logic [7:0] held;
    bit seen;
    held    = rd_diff(sel);
    lat     = 1;
    bcyc    = int'(rd_busy(sel));
    hold_ok = 1'b1;
    seen    = 1'b0;
    d       = '0;
    bo      = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      bcyc += int'(rd_busy(sel));
      if (rd_done(sel)) begin
        seen = 1'b1;
        d    = rd_diff(sel);
        bo   = rd_bo(sel);
      end else if (rd_diff(sel) !== held) begin
        hold_ok = 1'b0;
      end
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int sel, input logic [7:0] ai, input logic [7:0] bi,
                        output int waited, output int lat, output int bcyc,
                        output logic [7:0] d, output logic bo,
                        output bit hold_ok, output bit fall_ok);
    waited = 0;
    for (int i = 0; i < 64 && rd_busy(sel); i++) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (rd_busy(sel)) check_eq("idle_timeout", 32'd1, 32'd0);
    drive(sel, 1'b1, ai, bi);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ~ai, ~bi);
    wait_done(sel, lat, bcyc, d, bo, hold_ok);
    @(posedge clk);
    #1;
    fall_ok = !rd_done(sel) && !rd_busy(sel);
  endtask

  initial begin
    int         waited, lat, bcyc;
    logic [7:0] d;
    logic       bo;
    bit         hold_ok, fall_ok, done_seen;
    logic [7:0] exp_d;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy8, 1'b0);
    check_eq("rst_done", done8, 1'b0);
    check_eq("rst_diff", diff8, 8'h00);
    check_eq("rst_bo", bo8, 1'b0);
    check_eq("rst_busy_w3", busy3, 1'b0);
    check_eq("rst_busy_w4", busy4, 1'b0);
    rst = 1'b0;

    // 0x5A - 0x23 = 0x37
    run_op(0, 8'h5A, 8'h23, waited, lat, bcyc, d, bo, hold_ok, fall_ok);
    check_eq("t1_latency", lat, 9);
    check_eq("t1_busy_cycles", bcyc, 9);
    check_eq("t1_done_one_cycle", fall_ok, 1'b1);
    check_eq("t1_hold", hold_ok, 1'b1);
    check_eq("t1_diff", d, 8'h37);
    check_eq("t1_bo", bo, 1'b0);

    // 0x00 - 0x01 wraps to 0xFF with borrow
    run_op(0, 8'h00, 8'h01, waited, lat, bcyc, d, bo, hold_ok, fall_ok);
    check_eq("t2a_diff", d, 8'hFF);
    check_eq("t2a_bo", bo, 1'b1);
    // Back-to-back at the earliest legal edge
    run_op(0, 8'hFF, 8'hFF, waited, lat, bcyc, d, bo, hold_ok, fall_ok);
    check_eq("t2b_no_wait", waited, 0);
    check_eq("t2b_latency", lat, 9);
    check_eq("t2b_diff", d, 8'h00);
    check_eq("t2b_bo", bo, 1'b0);

    // start held high through SHIFT and DONE
    drive(0, 1'b1, 8'h80, 8'h01);
    @(posedge clk);
    #1;
    a8 = 8'h10;
    b8 = 8'h20;
    wait_done(0, lat, bcyc, d, bo, hold_ok);
    check_eq("t3a_latency", lat, 9);
    check_eq("t3a_diff", d, 8'h7F);
    check_eq("t3a_bo", bo, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t3_idle_gap_busy", busy8, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t3_reaccept_busy", busy8, 1'b1);
    start8 = 1'b0;
    wait_done(0, lat, bcyc, d, bo, hold_ok);
    check_eq("t3b_latency", lat, 9);
    check_eq("t3b_diff", d, 8'hF0);
    check_eq("t3b_bo", bo, 1'b1);
    @(posedge clk);
    #1;

    // Reset in the 4th SHIFT cycle discards the operation
    drive(0, 1'b1, 8'hF0, 8'h0F);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t4_busy", busy8, 1'b0);
    check_eq("t4_done", done8, 1'b0);
    check_eq("t4_diff", diff8, 8'h00);
    check_eq("t4_bo", bo8, 1'b0);
    done_seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) done_seen = 1'b1;
    end
    check_eq("t4_no_done", done_seen, 1'b0);
    run_op(0, 8'h09, 8'h03, waited, lat, bcyc, d, bo, hold_ok, fall_ok);
    check_eq("t4_after_diff", d, 8'h06);
    check_eq("t4_after_bo", bo, 1'b0);

    // WIDTH=3 exhaustive against a reference model
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        run_op(1, 8'(x), 8'(y), waited, lat, bcyc, d, bo, hold_ok, fall_ok);
        exp_d = 8'((x - y) & 7);
        check_eq($sformatf("w3_diff_%0d_%0d", x, y), d, exp_d);
        check_eq($sformatf("w3_bo_%0d_%0d", x, y), bo, (x < y) ? 1'b1 : 1'b0);
      end
    end

    // WIDTH=4 power-of-two counter case
    run_op(2, 8'h3, 8'h5, waited, lat, bcyc, d, bo, hold_ok, fall_ok);
    check_eq("w4_latency", lat, 5);
    check_eq("w4_busy_cycles", bcyc, 5);
    check_eq("w4_diff", d, 8'h0E);
    check_eq("w4_bo", bo, 1'b1);
    check_eq("w4_done_one_cycle", fall_ok, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
